// File: rtl/mem1_lsu.sv
// MEM1 stage: registers the EX bus, forms byte lanes and aligned store data,
// and runs the data-bus request/response handshake for loads and stores.
module mem1_lsu #(
    parameter int unsigned STAGE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [6:0]   stall,
    input  logic [142:0] ex2mem1_bus,
    output logic [146:0] mem12mem2_bus,
    output logic [37:0]  mem12rf_bus,
    output logic         load_hazard,
    output logic         stall_req,
    output logic         misalign,
    output logic         dreq_valid,
    input  logic         dreq_ready,
    output logic         dreq_we,
    output logic [31:0]  dreq_addr,
    output logic [3:0]   dreq_wstrb,
    output logic [31:0]  dreq_wdata,
    input  logic         drsp_valid,
    input  logic [31:0]  drsp_rdata
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned STRB_W   = 4;
    localparam logic [2:0]  IDX_CUR  = 3'(STAGE);
    localparam logic [2:0]  IDX_NXT  = 3'(STAGE + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic       en;
        logic       we;
        logic [2:0] size_sel;
        logic       uns;
    } lsu_op_t;

    typedef struct packed {
        lsu_op_t              lsu_op;
        logic [2:0]           sel_rf_res;
        logic                 rf_we;
        logic [4:0]           rf_waddr;
        logic [XLEN-1:0]      ex_result;
        logic [XLEN-1:0]      store_data;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      inst;
    } ex_bus_t;

    ex_bus_t            bus_q, bus_d;
    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;

    logic               stall_cur, stall_nxt;
    logic [1:0]         addr_lo;
    logic               is_byte, is_half, is_word;
    logic               mem_go;
    logic               rf_we_eff;
    logic [STRB_W-1:0]  ram_sel;
    logic [XLEN-1:0]    wdata;
    logic [XLEN-1:0]    rdata_out;
    logic               unused_stall;

    assign stall_cur    = stall[IDX_CUR];
    assign stall_nxt    = stall[IDX_NXT];
    assign unused_stall = ^stall;

    // Input register: bubble when this stage stalls but the next one drains
    always_comb begin
        bus_d = bus_q;
        if (stall_cur && !stall_nxt) begin
            bus_d = '0;
        end else if (!stall_cur) begin
            bus_d = ex_bus_t'(ex2mem1_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign addr_lo  = bus_q.ex_result[1:0];
    assign is_byte  = bus_q.lsu_op.size_sel[0];
    assign is_half  = bus_q.lsu_op.size_sel[1];
    assign is_word  = bus_q.lsu_op.size_sel[2];
    assign misalign = bus_q.lsu_op.en &
                      ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));
    assign mem_go   = bus_q.lsu_op.en & ~misalign;

    // Byte-lane select and lane-replicated store data
    always_comb begin
        ram_sel = '0;
        wdata   = bus_q.store_data;
        if (is_byte) begin
            wdata = {4{bus_q.store_data[7:0]}};
        end else if (is_half) begin
            wdata = {2{bus_q.store_data[15:0]}};
        end
        if (mem_go) begin
            if (is_byte) begin
                ram_sel = 4'b0001 << addr_lo;
            end else if (is_half) begin
                ram_sel = addr_lo[1] ? 4'b1100 : 4'b0011;
            end else if (is_word) begin
                ram_sel = 4'b1111;
            end
        end
    end

    // Handshake FSM: response in IDLE is ignored, DONE never reissues
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        dreq_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_go) begin
                    dreq_valid = 1'b1;
                    if (dreq_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (drsp_valid) begin
                    rdata_d = bus_q.lsu_op.we ? '0 : drsp_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stall_nxt) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall_req = mem_go & (state_q != ST_DONE);
    assign rdata_out = (state_q == ST_DONE) ? rdata_q : '0;
    assign rf_we_eff = bus_q.rf_we & ~misalign;

    assign dreq_we    = bus_q.lsu_op.we;
    assign dreq_addr  = {bus_q.ex_result[XLEN-1:2], 2'b00};
    assign dreq_wstrb = ram_sel;
    assign dreq_wdata = wdata;

    assign load_hazard = bus_q.lsu_op.en & ~bus_q.lsu_op.we & rf_we_eff;
    assign mem12rf_bus = {rf_we_eff, bus_q.rf_waddr, bus_q.ex_result};

    assign mem12mem2_bus = {bus_q.lsu_op, ram_sel, bus_q.sel_rf_res, rf_we_eff,
                            bus_q.rf_waddr, bus_q.ex_result, bus_q.pc,
                            bus_q.inst, rdata_out};

endmodule

// File: tb/tb_mem1_lsu.sv
// Directed bench for mem1_lsu; the pipeline controller is modelled by folding
// stall_req into stall[STAGE+1:0] alongside a downstream stall.
module tb_mem1_lsu;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ds = 1'b0;
    logic [6:0]   stall;
    logic [142:0] ex2mem1_bus = '0;
    logic [146:0] mem12mem2_bus;
    logic [37:0]  mem12rf_bus;
    logic         load_hazard;
    logic         stall_req;
    logic         misalign;
    logic         dreq_valid;
    logic         dreq_ready = 1'b0;
    logic         dreq_we;
    logic [31:0]  dreq_addr;
    logic [3:0]   dreq_wstrb;
    logic [31:0]  dreq_wdata;
    logic         drsp_valid = 1'b0;
    logic [31:0]  drsp_rdata = '0;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    assign stall = {ds, ds | stall_req, {5{ds | stall_req}}};

    always @(posedge clk) begin
        if (rst_n && dreq_valid && dreq_ready) acc_cnt <= acc_cnt + 1;
    end

    mem1_lsu #(.STAGE(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .ex2mem1_bus   (ex2mem1_bus),
        .mem12mem2_bus (mem12mem2_bus),
        .mem12rf_bus   (mem12rf_bus),
        .load_hazard   (load_hazard),
        .stall_req     (stall_req),
        .misalign      (misalign),
        .dreq_valid    (dreq_valid),
        .dreq_ready    (dreq_ready),
        .dreq_we       (dreq_we),
        .dreq_addr     (dreq_addr),
        .dreq_wstrb    (dreq_wstrb),
        .dreq_wdata    (dreq_wdata),
        .drsp_valid    (drsp_valid),
        .drsp_rdata    (drsp_rdata)
    );

    function automatic logic [142:0] mk(input logic [5:0] op, input logic [2:0] sel,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] res, input logic [31:0] sd,
                                        input logic [31:0] pc, input logic [31:0] inst);
        return {op, sel, we, wa, res, sd, pc, inst};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex2mem1_bus = mk(6'b101000, 3'b111, 1'b1, 5'd31, 32'hFFFF_FFF0, 32'h1, 32'h2, 32'h3);
        dreq_ready = 1'b1;
        tick();
        tick();
        checks++; if (mem12mem2_bus !== 147'd0) begin errors++; $display("FAIL reset_bus: got %h expected 0", mem12mem2_bus); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_req: got %b expected 0", stall_req); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid: got %b expected 0", dreq_valid); end
        checks++; if (mem12mem2_bus[31:0] !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem12mem2_bus[31:0]); end
        checks++; if (mem12rf_bus !== 38'd0) begin errors++; $display("FAIL reset_rf_bus: got %h expected 0", mem12rf_bus); end
        ex2mem1_bus = '0;
        dreq_ready = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        ex2mem1_bus = mk(6'b000000, 3'b001, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h40, 32'h0);
        drsp_valid = 1'b1;
        tick();
        ex2mem1_bus = '0;
        drsp_valid = 1'b0;
        checks++; if (mem12rf_bus !== {1'b1, 5'd5, 32'h0000_1234}) begin errors++; $display("FAIL alu_rf_bus: got %h expected %h", mem12rf_bus, {1'b1, 5'd5, 32'h0000_1234}); end
        checks++; if (load_hazard !== 1'b0) begin errors++; $display("FAIL alu_load_hazard: got %b expected 0", load_hazard); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL alu_dreq_valid: got %b expected 0", dreq_valid); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL alu_stall_req: got %b expected 0", stall_req); end
        checks++; if (mem12mem2_bus[140:133] !== 8'b0000_0011) begin errors++; $display("FAIL alu_sel_we: got %b expected 00000011", mem12mem2_bus[140:133]); end
        checks++; if (mem12mem2_bus[127:96] !== 32'h0000_1234) begin errors++; $display("FAIL alu_result: got %h expected 00001234", mem12mem2_bus[127:96]); end
        tick();
        checks++; if (mem12rf_bus !== 38'd0) begin errors++; $display("FAIL alu_drain: got %h expected 0", mem12rf_bus); end
    endtask

    task automatic test_lb();
        int acc0;
        acc0 = acc_cnt;
        ex2mem1_bus = mk(6'b100010, 3'b010, 1'b1, 5'd7, 32'h0000_1003, 32'h0, 32'h100, 32'h0);
        dreq_ready = 1'b1;
        tick();
        ex2mem1_bus = '0;
        checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b expected 1", dreq_valid); end
        checks++; if (dreq_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h expected 00001000", dreq_addr); end
        checks++; if (dreq_wstrb !== 4'b1000) begin errors++; $display("FAIL lb_wstrb: got %b expected 1000", dreq_wstrb); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lb_stall_c1: got %b expected 1", stall_req); end
        checks++; if (load_hazard !== 1'b1) begin errors++; $display("FAIL lb_load_hazard: got %b expected 1", load_hazard); end
        tick();
        dreq_ready = 1'b0;
        drsp_valid = 1'b1;
        drsp_rdata = 32'hAABB_CCDD;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lb_stall_c2: got %b expected 1", stall_req); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL lb_wait_valid: got %b expected 0", dreq_valid); end
        tick();
        drsp_valid = 1'b0;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lb_stall_done: got %b expected 0", stall_req); end
        checks++; if (mem12mem2_bus[31:0] !== 32'hAABB_CCDD) begin errors++; $display("FAIL lb_rdata: got %h expected aabbccdd", mem12mem2_bus[31:0]); end
        checks++; if (mem12mem2_bus[140:137] !== 4'b1000) begin errors++; $display("FAIL lb_ram_sel: got %b expected 1000", mem12mem2_bus[140:137]); end
        tick();
        checks++; if (mem12mem2_bus !== 147'd0) begin errors++; $display("FAIL lb_drain: got %h expected 0", mem12mem2_bus); end
        checks++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL lb_accepts: got %0d expected 1", acc_cnt - acc0); end
    endtask

    task automatic test_sh_backpressure();
        int acc0;
        acc0 = acc_cnt;
        ex2mem1_bus = mk(6'b110100, 3'b000, 1'b0, 5'd0, 32'h0000_2002, 32'h0000_BEEF, 32'h200, 32'h0);
        dreq_ready = 1'b0;
        tick();
        ex2mem1_bus = '0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (dreq_valid !== 1'b1 || dreq_wdata !== 32'hBEEF_BEEF || dreq_wstrb !== 4'b1100 ||
                          dreq_addr !== 32'h0000_2000 || dreq_we !== 1'b1)
            begin errors++; $display("FAIL sh_hold_%0d: got v=%b wd=%h st=%b a=%h we=%b expected v=1 wd=beefbeef st=1100 a=00002000 we=1", i, dreq_valid, dreq_wdata, dreq_wstrb, dreq_addr, dreq_we); end
            if (i < 2) tick();
        end
        dreq_ready = 1'b1;
        tick();
        drsp_valid = 1'b1;
        drsp_rdata = 32'hDEAD_BEEF;
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL sh_wait_valid: got %b expected 0", dreq_valid); end
        tick();
        drsp_valid = 1'b0;
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL sh_done_valid: got %b expected 0", dreq_valid); end
        checks++; if (mem12mem2_bus[31:0] !== 32'd0) begin errors++; $display("FAIL sh_rdata: got %h expected 0", mem12mem2_bus[31:0]); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL sh_stall_done: got %b expected 0", stall_req); end
        tick();
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL sh_no_reissue: got %b expected 0", dreq_valid); end
        dreq_ready = 1'b0;
        checks++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL sh_accepts: got %0d expected 1", acc_cnt - acc0); end
    endtask

    task automatic test_misalign();
        ex2mem1_bus = mk(6'b101000, 3'b010, 1'b1, 5'd9, 32'h0000_3001, 32'h0, 32'h300, 32'h0);
        dreq_ready = 1'b1;
        tick();
        ex2mem1_bus = '0;
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misalign); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", dreq_valid); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mis_stall_req: got %b expected 0", stall_req); end
        checks++; if (mem12mem2_bus[133] !== 1'b0) begin errors++; $display("FAIL mis_rf_we_bus: got %b expected 0", mem12mem2_bus[133]); end
        checks++; if (mem12rf_bus[37] !== 1'b0) begin errors++; $display("FAIL mis_rf_we_byp: got %b expected 0", mem12rf_bus[37]); end
        checks++; if (mem12mem2_bus[140:137] !== 4'b0000) begin errors++; $display("FAIL mis_ram_sel: got %b expected 0000", mem12mem2_bus[140:137]); end
        checks++; if (load_hazard !== 1'b0) begin errors++; $display("FAIL mis_load_hazard: got %b expected 0", load_hazard); end
        tick();
        dreq_ready = 1'b0;
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign); end
    endtask

    task automatic test_done_hold();
        int acc0;
        acc0 = acc_cnt;
        ex2mem1_bus = mk(6'b101000, 3'b010, 1'b1, 5'd3, 32'h0000_4000, 32'h0, 32'h400, 32'h0);
        dreq_ready = 1'b1;
        tick();
        ex2mem1_bus = '0;
        checks++; if (dreq_valid !== 1'b1 || dreq_wstrb !== 4'b1111) begin errors++; $display("FAIL hold_req: got v=%b st=%b expected v=1 st=1111", dreq_valid, dreq_wstrb); end
        tick();
        dreq_ready = 1'b0;
        drsp_valid = 1'b1;
        drsp_rdata = 32'h1122_3344;
        ds = 1'b1;
        tick();
        drsp_valid = 1'b0;
        dreq_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (mem12mem2_bus[31:0] !== 32'h1122_3344) begin errors++; $display("FAIL hold_rdata_%0d: got %h expected 11223344", i, mem12mem2_bus[31:0]); end
            checks++; if (dreq_valid !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL hold_quiet_%0d: got v=%b sr=%b expected v=0 sr=0", i, dreq_valid, stall_req); end
            checks++; if (mem12rf_bus !== {1'b1, 5'd3, 32'h0000_4000}) begin errors++; $display("FAIL hold_rf_bus_%0d: got %h expected %h", i, mem12rf_bus, {1'b1, 5'd3, 32'h0000_4000}); end
            if (i == 0) tick();
        end
        ds = 1'b0;
        tick();
        dreq_ready = 1'b0;
        checks++; if (mem12mem2_bus !== 147'd0) begin errors++; $display("FAIL hold_leave: got %h expected 0", mem12mem2_bus); end
        checks++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL hold_accepts: got %0d expected 1", acc_cnt - acc0); end
    endtask

    task automatic test_reset_mid();
        ex2mem1_bus = mk(6'b101000, 3'b010, 1'b1, 5'd4, 32'h0000_5000, 32'h0, 32'h500, 32'h0);
        dreq_ready = 1'b1;
        tick();
        ex2mem1_bus = '0;
        tick();
        dreq_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drsp_valid = 1'b1;
        drsp_rdata = 32'hCAFE_F00D;
        tick();
        drsp_valid = 1'b0;
        checks++; if (mem12mem2_bus !== 147'd0) begin errors++; $display("FAIL rstmid_bus: got %h expected 0", mem12mem2_bus); end
        checks++; if (stall_req !== 1'b0 || dreq_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got sr=%b v=%b expected 0 0", stall_req, dreq_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_sh_backpressure();
        test_misalign();
        test_done_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
